// File: rtl/pe_result_drain.sv
// Result collector for the PE/MAC array: captures batches of N signed totals into a
// two-bank ping-pong buffer and serializes them onto a row/column-tagged valid/ready stream.
module pe_result_drain #(
  parameter int N           = 8,
  parameter int ROWS        = 8,
  parameter int ACCUM_WIDTH = 32,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   cap,
  input  logic [ACCUM_WIDTH-1:0] totals [0:N-1],
  input  logic [N-1:0]           errs,
  output logic                   cap_rdy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACCUM_WIDTH-1:0] out_data,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic                   out_last,
  output logic                   out_err,
  output logic                   ovf
);

  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                 state_r;
  logic [ACCUM_WIDTH-1:0] bank_r [2][N];
  logic [N-1:0]           err_r [2];
  logic [RW-1:0]          tag_r [2];
  logic [1:0]             full_r;
  logic                   wp_r;
  logic                   rp_r;
  logic [CW-1:0]          col_r;
  logic [RW-1:0]          wr_row_r;
  logic                   ovf_r;
  logic [ACCUM_WIDTH-1:0] out_data_r;
  logic [RW-1:0]          out_row_r;
  logic                   out_last_r;
  logic                   out_err_r;

  logic                   cap_ok_s;
  logic                   drop_s;
  logic                   xfer_s;
  logic                   release_s;
  logic [1:0]             full_set_s;
  logic [1:0]             full_clr_s;
  logic                   ld_s;
  logic                   ld_bank_s;
  logic [CW-1:0]          ld_col_s;

  assign cap_rdy   = ~full_r[wp_r];
  assign out_valid = (state_r == DRAIN);
  assign out_data  = out_data_r;
  assign out_row   = out_row_r;
  assign out_col   = col_r;
  assign out_last  = out_last_r;
  assign out_err   = out_err_r;
  assign ovf       = ovf_r;

  // Capture/drop decode and the element to present next (ld_*), all from registered state.
  always_comb begin
    cap_ok_s   = ~flush & cap & ~full_r[wp_r];
    drop_s     = ~flush & cap & full_r[wp_r];
    xfer_s     = (state_r == DRAIN) & out_ready;
    release_s  = xfer_s & (col_r == COL_LAST);
    full_set_s = 2'b00;
    full_clr_s = 2'b00;
    if (cap_ok_s) begin
      full_set_s = wp_r ? 2'b10 : 2'b01;
    end else begin
      full_set_s = 2'b00;
    end
    if (release_s) begin
      full_clr_s = rp_r ? 2'b10 : 2'b01;
    end else begin
      full_clr_s = 2'b00;
    end
    ld_s      = 1'b0;
    ld_bank_s = rp_r;
    ld_col_s  = {CW{1'b0}};
    case (state_r)
      IDLE: ld_s = full_r[rp_r];
      DRAIN: begin
        // The other bank is judged on its pre-edge flag, so a same-edge capture waits a cycle.
        if (release_s) begin
          ld_s      = full_r[~rp_r];
          ld_bank_s = ~rp_r;
        end else if (xfer_s) begin
          ld_s     = 1'b1;
          ld_col_s = col_r + CW'(1'b1);
        end else begin
          ld_s = 1'b0;
        end
      end
      default: ld_s = 1'b0;
    endcase
  end

  // Capture side: write pointer, row tagging and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r     <= 1'b0;
      wr_row_r <= {RW{1'b0}};
      ovf_r    <= 1'b0;
      tag_r[0] <= {RW{1'b0}};
      tag_r[1] <= {RW{1'b0}};
    end else if (flush) begin
      wp_r     <= 1'b0;
      wr_row_r <= {RW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (cap_ok_s) begin
        wp_r        <= ~wp_r;
        tag_r[wp_r] <= wr_row_r;
        wr_row_r    <= (wr_row_r == ROW_LAST) ? {RW{1'b0}} : wr_row_r + RW'(1'b1);
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Bank payload storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        err_r[b] <= {N{1'b0}};
        for (int i = 0; i < N; i++) begin
          bank_r[b][i] <= {ACCUM_WIDTH{1'b0}};
        end
      end
    end else if (cap_ok_s) begin
      err_r[wp_r] <= errs;
      for (int i = 0; i < N; i++) begin
        bank_r[wp_r][i] <= totals[i];
      end
    end
  end

  // Bank occupancy; set and clear never target the same bank in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 2'b00;
    end else if (flush) begin
      full_r <= 2'b00;
    end else begin
      full_r <= (full_r | full_set_s) & ~full_clr_s;
    end
  end

  // Drain FSM with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rp_r       <= 1'b0;
      col_r      <= {CW{1'b0}};
      out_data_r <= {ACCUM_WIDTH{1'b0}};
      out_row_r  <= {RW{1'b0}};
      out_last_r <= 1'b0;
      out_err_r  <= 1'b0;
    end else if (flush) begin
      state_r    <= IDLE;
      rp_r       <= 1'b0;
      col_r      <= {CW{1'b0}};
      out_data_r <= {ACCUM_WIDTH{1'b0}};
      out_row_r  <= {RW{1'b0}};
      out_last_r <= 1'b0;
      out_err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ld_s) begin
            state_r <= DRAIN;
            col_r   <= ld_col_s;
          end else begin
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          if (release_s) begin
            rp_r    <= ~rp_r;
            col_r   <= ld_col_s;
            state_r <= ld_s ? DRAIN : IDLE;
          end else if (xfer_s) begin
            col_r <= ld_col_s;
          end else begin
            col_r <= col_r;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (ld_s) begin
        out_data_r <= bank_r[ld_bank_s][ld_col_s];
        out_err_r  <= err_r[ld_bank_s][ld_col_s];
        out_row_r  <= tag_r[ld_bank_s];
        out_last_r <= (tag_r[ld_bank_s] == ROW_LAST) && (ld_col_s == COL_LAST);
      end else if (release_s) begin
        out_data_r <= {ACCUM_WIDTH{1'b0}};
        out_err_r  <= 1'b0;
        out_row_r  <= {RW{1'b0}};
        out_last_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Randomized bench for pe_result_drain against a queue-of-batches reference model.
module tb_pe_result_drain;

  localparam int N    = 8;
  localparam int ROWS = 8;
  localparam int AW   = 32;
  localparam int RW   = 3;
  localparam int CW   = 3;
  localparam int VW   = 1 + AW + RW + CW + 4;
  localparam logic [VW-1:0] RST_VEC = {{(VW-2){1'b0}}, 2'b10};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          cap = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] totals [0:N-1];
  logic [N-1:0]  errs = '0;
  logic          cap_rdy, out_valid, out_last, out_err, ovf;
  logic [AW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic [VW-1:0] act;

  pe_result_drain #(.N(N), .ROWS(ROWS), .ACCUM_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cap(cap), .totals(totals), .errs(errs),
    .cap_rdy(cap_rdy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .out_err(out_err), .ovf(ovf)
  );

  assign act = {out_valid, out_data, out_row, out_col, out_last, out_err, cap_rdy, ovf};

  always #5 clk = ~clk;

  // Reference model: a queue of accepted batches plus the position within the head batch.
  typedef struct packed {
    logic [N-1:0][AW-1:0] d;
    logic [N-1:0]         e;
    logic [RW-1:0]        row;
  } batch_t;

  batch_t mq[$];
  int     m_col, m_row;
  bit     m_valid, m_ovf;
  int     n_tests = 0;
  int     n_fail = 0;

  task automatic model_clear();
    mq.delete();
    m_col = 0; m_row = 0; m_valid = 1'b0; m_ovf = 1'b0;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    batch_t h;
    logic   rdy;
    rdy = (mq.size() < 2);
    if (m_valid) begin
      h = mq[0];
      return {1'b1, h.d[m_col], h.row, CW'(m_col),
              (h.row == RW'(ROWS - 1)) && (m_col == N - 1), h.e[m_col], rdy, m_ovf};
    end else begin
      return {1'b0, {AW{1'b0}}, {RW{1'b0}}, {CW{1'b0}}, 1'b0, 1'b0, rdy, m_ovf};
    end
  endfunction

  // One clock: model reacts to the inputs seen at the rising edge; returns at the falling edge.
  task automatic cycle();
    int     old_n;
    batch_t b;
    @(posedge clk);
    old_n = mq.size();
    if (flush) begin
      model_clear();
    end else begin
      if (m_valid && out_ready) begin
        if (m_col == N - 1) begin
          void'(mq.pop_front());
          m_col = 0;
          m_valid = (mq.size() > 0);
        end else begin
          m_col++;
        end
      end else if (!m_valid) begin
        m_valid = (old_n > 0);
      end
      if (cap) begin
        if (old_n < 2) begin
          for (int i = 0; i < N; i++) b.d[i] = totals[i];
          b.e = errs;
          b.row = RW'(m_row);
          mq.push_back(b);
          m_row = (m_row + 1) % ROWS;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_batch();
    for (int i = 0; i < N; i++) totals[i] = $urandom;
    errs = N'($urandom);
  endtask

  task automatic do_flush();
    flush = 1'b1; cycle(); flush = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    for (int i = 0; i < N; i++) totals[i] = '0;
    #12;
    n_tests++;
    if (act !== RST_VEC) begin n_fail++; $display("FAIL reset_state: got %h expected %h", act, RST_VEC); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_tests++;
    if (act !== RST_VEC || act !== exp_vec()) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", act, RST_VEC); end
  endtask

  task automatic test_single();
    logic [AW-1:0] exp_d;
    totals[0] = 32'hFFFF_FFFF;
    for (int i = 1; i < N; i++) totals[i] = AW'(i + 1);
    errs = '0; out_ready = 1'b1; cap = 1'b1;
    cycle();
    cap = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got valid=%b expected 0", out_valid); end
    cycle();
    for (int i = 0; i < N; i++) begin
      exp_d = (i == 0) ? {AW{1'b1}} : AW'(i + 1);
      n_tests++;
      if ({out_valid, out_col, out_row, out_data} !== {1'b1, CW'(i), {RW{1'b0}}, exp_d}) begin
        n_fail++;
        $display("FAIL single_elem%0d: got v=%b col=%0d row=%0d data=%h expected v=1 col=%0d row=0 data=%h",
                 i, out_valid, out_col, out_row, out_data, i, exp_d);
      end
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL single_model%0d: got %h expected %h", i, act, exp_vec()); end
      cycle();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_end: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_errs();
    do_flush();
    rand_batch();
    errs = 8'b0010_0001; out_ready = 1'b1; cap = 1'b1;
    cycle();
    cap = 1'b0; errs = '0;
    cycle();
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if ({out_valid, out_col, out_err} !== {1'b1, CW'(i), (i == 0 || i == 5) ? 1'b1 : 1'b0}) begin
        n_fail++;
        $display("FAIL err_col%0d: got v=%b col=%0d err=%b", i, out_valid, out_col, out_err);
      end
      cycle();
    end
  endtask

  task automatic test_pingpong();
    do_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_batch();
      cap = 1'b1;
      cycle();
      cap = 1'b0;
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL pp_cap%0d: got %h expected %h", k, act, exp_vec()); end
      if (k == 1) begin
        n_tests++;
        if ({cap_rdy, ovf} !== 2'b00) begin n_fail++; $display("FAIL pp_full: got cap_rdy=%b ovf=%b expected 0 0", cap_rdy, ovf); end
      end
      if (k == 2) begin
        n_tests++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL pp_ovf: got ovf=%b expected 1", ovf); end
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      n_tests++;
      if ({out_valid, out_row, out_col} !== {1'b1, RW'(i / N), CW'(i % N)}) begin
        n_fail++;
        $display("FAIL pp_stream%0d: got v=%b row=%0d col=%0d", i, out_valid, out_row, out_col);
      end
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL pp_model%0d: got %h expected %h", i, act, exp_vec()); end
      cycle();
    end
    n_tests++;
    if (out_valid !== 1'b0 || act !== exp_vec()) begin n_fail++; $display("FAIL pp_end: got %h expected %h", act, exp_vec()); end
  endtask

  task automatic test_row_wrap();
    int nb = 0, xfers = 0, lasts = 0, last_at = -1, row_wrap = -1;
    do_flush();
    out_ready = 1'b1;
    for (int c = 0; c < (ROWS + 1) * N + 20; c++) begin
      cap = (nb <= ROWS) && (mq.size() < 2);
      if (cap) begin rand_batch(); nb++; end
      if (out_valid && out_last) begin lasts++; last_at = xfers; end
      if (out_valid && xfers == ROWS * N) row_wrap = int'(out_row);
      if (out_valid) xfers++;
      cycle();
      cap = 1'b0;
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL wrap_model%0d: got %h expected %h", c, act, exp_vec()); end
    end
    n_tests++;
    if (lasts != 1 || last_at != ROWS * N - 1) begin n_fail++; $display("FAIL wrap_last: got count=%0d at=%0d expected 1 at %0d", lasts, last_at, ROWS * N - 1); end
    n_tests++;
    if (row_wrap != 0 || xfers != (ROWS + 1) * N) begin n_fail++; $display("FAIL wrap_row: got row=%0d xfers=%0d expected 0 %0d", row_wrap, xfers, (ROWS + 1) * N); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] prev;
    bit            hold;
    do_flush();
    for (int c = 0; c < 400; c++) begin
      out_ready = $urandom_range(0, 1);
      cap = ($urandom_range(0, 2) == 0);
      rand_batch();
      prev = act;
      hold = out_valid && !out_ready;
      cycle();
      cap = 1'b0;
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL bp_model%0d: got %h expected %h", c, act, exp_vec()); end
      if (hold) begin
        n_tests++;
        if (act[VW-1:2] !== prev[VW-1:2]) begin n_fail++; $display("FAIL bp_stable%0d: got %h expected %h", c, act[VW-1:2], prev[VW-1:2]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_flush();
    rand_batch();
    out_ready = 1'b1; cap = 1'b1;
    cycle();
    cap = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    n_tests++;
    if ({out_valid, out_col} !== {1'b1, CW'(3)}) begin n_fail++; $display("FAIL mid_col3: got v=%b col=%0d", out_valid, out_col); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (act !== RST_VEC) begin n_fail++; $display("FAIL mid_reset: got %h expected %h", act, RST_VEC); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    rand_batch();
    cap = 1'b1;
    cycle();
    cap = 1'b0;
    cycle();
    n_tests++;
    if ({out_valid, out_col, out_row, out_data} !== {1'b1, {CW{1'b0}}, {RW{1'b0}}, totals[0]}) begin
      n_fail++;
      $display("FAIL mid_restart: got v=%b col=%0d row=%0d data=%h expected data=%h", out_valid, out_col, out_row, out_data, totals[0]);
    end
    for (int i = 0; i < N; i++) cycle();
  endtask

  task automatic test_flush_cap();
    out_ready = 1'b0;
    rand_batch();
    cap = 1'b1;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; cap = 1'b0;
    n_tests++;
    if (act !== RST_VEC) begin n_fail++; $display("FAIL flush_clear: got %h expected %h", act, RST_VEC); end
    cycle();
    cycle();
    n_tests++;
    if (act !== RST_VEC || act !== exp_vec()) begin n_fail++; $display("FAIL flush_cap_ignored: got %h expected %h", act, RST_VEC); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_errs();
    test_pingpong();
    test_row_wrap();
    test_backpressure();
    test_reset_mid();
    test_flush_cap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Downstream collector for the PE/MAC array. It captures one batch of N signed accumulator totals and their per-PE error flags when the array signals completion. Captured batches sit in a two-bank ping-pong buffer, so the array can start its next batch while the previous one drains. Each batch is serialized onto a valid/ready stream tagged with row/column indices, and the row index wraps once per full matrix of ROWS batches.

## Interface
- N, default 8: totals per batch (PE count); ≥2
- ROWS, default 8: batches per result matrix; ≥2
- ACCUM_WIDTH, default 32: signed total width
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of banks, counters and sticky flags
- cap  input  1  one-cycle pulse: totals/errs valid, capture batch
- totals  input  [ACCUM_WIDTH-1:0] x [0:N-1]  signed totals, element i = column i
- errs  input  [N-1:0]  per-PE overflow flags
- cap_rdy  output  1  at least one bank free
- out_valid  output  1  out_* holds a valid element
- out_ready  input  1  consumer accepts element
- out_data  output  ACCUM_WIDTH  signed total
- out_row  output  max(1,$clog2(ROWS))  row index of element
- out_col  output  max(1,$clog2(N))  column index of element
- out_last  output  1  element is row ROWS-1, col N-1
- out_err  output  1  errs bit of this element
- ovf  output  1  sticky: capture dropped

## Operation
- Storage: two banks of N×ACCUM_WIDTH totals, N err bits, a row tag and a full flag each. Capture pointer wp and drain pointer rp, each 1 bit.
- Capture: cap && cap_rdy writes bank[wp], sets full[wp], stores row tag = wr_row, toggles wp. wr_row then increments and wraps ROWS-1 → 0.
- Drop: cap && !cap_rdy leaves the banks untouched, sets ovf and does not advance wr_row.
- cap_rdy = !full[wp]. It is a combinational function of registered state only, with no dependence on same-cycle out_ready.
- Drain FSM, states IDLE and DRAIN:
  - IDLE: out_valid=0. If full[rp], go to DRAIN with col=0.
  - DRAIN: out_valid=1, out_data=bank[rp][col], out_err=errs[rp][col], out_row=tag[rp], out_col=col.
  - DRAIN, on out_valid&&out_ready with col<N-1: col++.
  - DRAIN, on out_valid&&out_ready with col=N-1: clear full[rp], toggle rp, col=0. Stay in DRAIN if the other bank is already full (checked before this cycle's capture), otherwise go to IDLE.
- out_last = out_valid && tag[rp]==ROWS-1 && col==N-1.
- out_* stay stable while out_valid && !out_ready (AXI-style rule). out_valid never deasserts without a transfer.
- Simultaneous capture into bank[wp] and drain release of bank[rp] is legal because they are different banks.
- flush: full flags, wp, rp, col, wr_row and ovf are cleared, the FSM goes to IDLE, and a cap in the same cycle is ignored. flush has priority over everything.
- No arithmetic on data: totals pass bit-exact, sign preserved.

## Timing
- Reset/flush values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, out_err=0, ovf=0, cap_rdy=1.
- Latency: cap at edge t → out_valid=1 in cycle t+1 (IDLE→DRAIN on the capture edge+1), first element visible one cycle after capture.
- Throughput: one element per cycle with out_ready held high. Banks drain back-to-back with no bubble between them.
- Bank release at the transfer edge of col N-1; cap_rdy rises in the following cycle. A cap in the release cycle while both banks are full is dropped (ovf).
- Reset mid-drain: all state clears immediately (asynchronous). The partial batch is lost and the next capture restarts at row 0.

## Test plan
- Single batch: cap with totals={-1,2,...,8}, errs=0, out_ready=1. Required: out_valid for 8 consecutive cycles starting cycle after cap, out_col 0..7, out_data exact, out_row=0, then out_valid=0.
- Backpressure: toggle out_ready randomly at 50%. Required: each element held stable until accepted, no duplicates or skips, order 0..N-1.
- Ping-pong: out_ready=0, cap twice. Required: cap_rdy=0 after second capture, ovf=0. Then a third cap → ovf=1, the third batch never appears. Release out_ready → 16 elements, rows 0 then 1, no bubble.
- Row wrap/last: ROWS batches drained. Required: out_last high only on the final element of batch ROWS-1. Batch ROWS is tagged out_row=0.
- Error pass-through: errs=8'b0010_0001. Required: out_err=1 exactly at cols 0 and 5.
- Reset mid-drain: assert rst_n=0 at col 3. Required: all outputs at reset values that cycle, cap_rdy=1. A new cap drains from col 0 with row 0.
